// File: rtl/ones_arb_pkg.sv
// Shared types for the ones-counter arbiter: FSM state encoding.
package ones_arb_pkg;

  typedef enum logic [1:0] {
    A_idle   = 2'd0,
    A_launch = 2'd1,
    A_run    = 2'd2,
    A_resp   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/ones_count_arbiter_rr_pick.sv
// Round-robin picker: first raised request strictly after last_gnt, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_gnt,
  output logic [N_REQ-1:0] sel,
  output logic [IDX_W-1:0] sel_idx
);

  // Scan candidates last_gnt+1 .. last_gnt+N_REQ (mod N_REQ); keep the first hit
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    sel     = {N_REQ{1'b0}};
    sel_idx = {IDX_W{1'b0}};
    found   = 1'b0;
    cand    = {IDX_W{1'b0}};
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last_gnt) + k) % N_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        sel[cand] = 1'b1;
        sel_idx   = cand;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/ones_count_arbiter.sv
// Round-robin arbiter/sequencer sharing one ones-counter unit among N_REQ clients.
// Grants one request at a time, launches the unit, waits for completion or a
// watchdog timeout, then returns the result to the granted requester.
module ones_count_arbiter
  import ones_arb_pkg::*;
#(
  parameter int  N_REQ   = 4,
  parameter int  DATA_W  = 8,
  parameter int  TIMEOUT = 64,
  localparam int CNT_W   = $clog2(DATA_W + 1)
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [CNT_W-1:0]          rsp_count,
  output logic                      rsp_err,
  output logic                      cu_start,
  output logic [DATA_W-1:0]         cu_data,
  input  logic                      cu_busy,
  input  logic [CNT_W-1:0]          cu_count
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  arb_state_t        state_q, state_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              cu_start_q, cu_start_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0]  rsp_count_q, rsp_count_d;
  logic              rsp_err_q, rsp_err_d;
  logic [N_REQ-1:0]  gnt_s;
  logic [N_REQ-1:0]  sel_s;
  logic [IDX_W-1:0]  sel_idx_s;
  logic [DATA_W-1:0] slot_s [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
    assign slot_s[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req      (req),
    .last_gnt (last_gnt_q),
    .sel      (sel_s),
    .sel_idx  (sel_idx_s)
  );

  // Next-state, datapath and next-output decode; outputs are registered one cycle ahead
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    idx_d       = idx_q;
    last_gnt_d  = last_gnt_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    wd_d        = wd_q;
    cu_start_d  = 1'b0;
    rsp_valid_d = {N_REQ{1'b0}};
    rsp_count_d = {CNT_W{1'b0}};
    rsp_err_d   = 1'b0;
    gnt_s       = {N_REQ{1'b0}};
    case (state_q)
      A_idle: begin
        if (|req) begin
          gnt_s      = sel_s;
          op_d       = slot_s[sel_idx_s];
          idx_d      = sel_idx_s;
          cu_start_d = 1'b1;
          state_d    = A_launch;
        end else begin
          state_d = A_idle;
        end
      end
      A_launch: begin
        wd_d    = {WD_W{1'b0}};
        state_d = A_run;
      end
      A_run: begin
        wd_d = wd_q + WD_W'(1);
        // Completion wins over a timeout landing in the same cycle
        if (!cu_busy) begin
          cnt_d       = cu_count;
          err_d       = 1'b0;
          rsp_valid_d = {{(N_REQ-1){1'b0}}, 1'b1} << idx_q;
          rsp_count_d = cu_count;
          rsp_err_d   = 1'b0;
          state_d     = A_resp;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          cnt_d       = {CNT_W{1'b0}};
          err_d       = 1'b1;
          rsp_valid_d = {{(N_REQ-1){1'b0}}, 1'b1} << idx_q;
          rsp_count_d = {CNT_W{1'b0}};
          rsp_err_d   = 1'b1;
          state_d     = A_resp;
        end else begin
          state_d = A_run;
        end
      end
      A_resp: begin
        last_gnt_d = idx_q;
        state_d    = A_idle;
      end
      default: begin
        state_d    = A_idle;
        op_d       = {DATA_W{1'b0}};
        idx_d      = {IDX_W{1'b0}};
        last_gnt_d = IDX_W'(N_REQ - 1);
        cnt_d      = {CNT_W{1'b0}};
        err_d      = 1'b0;
        wd_d       = {WD_W{1'b0}};
      end
    endcase
  end

  // State, operand/result registers, watchdog and registered outputs
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= A_idle;
      op_q        <= {DATA_W{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      last_gnt_q  <= IDX_W'(N_REQ - 1);
      cnt_q       <= {CNT_W{1'b0}};
      err_q       <= 1'b0;
      wd_q        <= {WD_W{1'b0}};
      cu_start_q  <= 1'b0;
      rsp_valid_q <= {N_REQ{1'b0}};
      rsp_count_q <= {CNT_W{1'b0}};
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      last_gnt_q  <= last_gnt_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      wd_q        <= wd_d;
      cu_start_q  <= cu_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_count_q <= rsp_count_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Grant is combinational from req, so hold it low while reset is asserted
  assign gnt       = rst_b ? gnt_s : {N_REQ{1'b0}};
  assign rsp_valid = rsp_valid_q;
  assign rsp_count = rsp_count_q;
  assign rsp_err   = rsp_err_q;
  assign cu_start  = cu_start_q;
  assign cu_data   = op_q;

endmodule
